// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the Mem-stage data memory responder: word and
// address widths, default configuration, FSM state encoding and an
// address-window helper.
package data_mem_responder_pkg;

  localparam int WORD_LEN    = 32;
  localparam int ADDRESS_LEN = 32;

  localparam logic [ADDRESS_LEN-1:0] DEFAULT_ADDR_BASE   = 32'd1024;
  localparam int                     DEFAULT_DEPTH       = 64;
  localparam int                     DEFAULT_WAIT_CYCLES = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } dmem_state_e;

  // True when a byte address falls inside [base, base + 4*depth).
  // The subtraction wraps for addresses below base, so the lower bound
  // is checked explicitly.
  function automatic logic addr_in_window(input logic [ADDRESS_LEN-1:0] addr,
                                          input logic [ADDRESS_LEN-1:0] base,
                                          input logic [31:0]            depth);
    logic [ADDRESS_LEN-1:0] woff;
    woff = (addr - base) >> 2;
    return (addr >= base) && (woff < depth);
  endfunction

endpackage

// File: rtl/data_mem_responder_dmem_array.sv
// Word array behind the responder: synchronous write port and a registered
// read port. The read register can also be loaded with an explicit value
// (zero for illegal accesses, or forwarded data), so it is the single
// source of the responder's rdata output.
module dmem_array
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = WORD_LEN,
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [IDX_W-1:0] raddr_i,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] ld_data_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Storage update; contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read register: explicit load wins over an array read, otherwise hold.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (ld_i) begin
      rdata_q <= ld_data_i;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Mem-stage data memory responder. Accepts held word read/write requests,
// services them from dmem_array after WAIT_CYCLES wait states, pulses ready
// (with err for illegal/out-of-range accesses) and drives freeze to stall
// the pipeline while an access is outstanding.
// Optional feature macro: DMEM_WRITE_BUFFER_EN adds a one-entry posted-write
// buffer with read forwarding; the default build has no buffer.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter logic [ADDRESS_LEN-1:0] ADDR_BASE   = DEFAULT_ADDR_BASE,
  parameter int                     DEPTH       = DEFAULT_DEPTH,
  parameter int                     WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_rd,
  input  logic                   req_wr,
  input  logic [ADDRESS_LEN-1:0] req_addr,
  input  logic [WORD_LEN-1:0]    req_wdata,
  output logic                   ready,
  output logic [WORD_LEN-1:0]    rdata,
  output logic                   freeze,
  output logic                   err
);

  localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  // FSM state and captured request
  dmem_state_e          state_q;
  logic [3:0]           cnt_q;
  logic [IDX_W-1:0]     idx_q;
  logic [WORD_LEN-1:0]  wdata_q;
  logic                 rd_q;
  logic                 wr_q;
  logic                 oor_q;
  logic                 ready_q;
  logic                 err_q;

  // Decode of the live request
  logic                 req_any_s;
  logic                 oor_now_s;
  logic [IDX_W-1:0]     idx_now_s;
  logic                 done_go_s;
  logic                 illegal_s;
  logic                 accept_slow_s;

  // Array control
  logic                 arr_we_s;
  logic [IDX_W-1:0]     arr_waddr_s;
  logic [WORD_LEN-1:0]  arr_wdata_s;
  logic                 arr_re_s;
  logic [IDX_W-1:0]     arr_raddr_s;
  logic                 arr_ld_s;
  logic [WORD_LEN-1:0]  arr_ld_data_s;
  logic [WORD_LEN-1:0]  arr_rdata_s;

`ifdef DMEM_WRITE_BUFFER_EN
  // Posted-write buffer
  logic                 buf_valid_q;
  logic [IDX_W-1:0]     buf_idx_q;
  logic [WORD_LEN-1:0]  buf_data_q;
  logic [3:0]           drain_cnt_q;
  logic                 buf_fill_s;
  logic                 fwd_s;
  logic                 fast_oor_wr_s;
  logic                 accept_fast_s;
  logic                 drain_now_s;
`endif

  // Address decode of the live request and end-of-wait detection.
  always_comb begin
    req_any_s = req_rd | req_wr;
    oor_now_s = ~addr_in_window(req_addr, ADDR_BASE, 32'(DEPTH));
    idx_now_s = IDX_W'((req_addr - ADDR_BASE) >> 2);
    // rst gating keeps an access that is being reset from touching the array
    done_go_s = (state_q == ST_WAIT) && (cnt_q == 4'd0) && req_any_s && !rst;
    illegal_s = (rd_q & wr_q) | oor_q;
  end

`ifdef DMEM_WRITE_BUFFER_EN
  // Acceptance decisions in IDLE: fast (buffer fill, forward, rejected
  // write) versus the normal wait-state path, which waits for the buffer
  // to drain so the two array write sources never collide.
  always_comb begin
    buf_fill_s    = (state_q == ST_IDLE) && req_wr && !req_rd && !oor_now_s && !buf_valid_q;
    fwd_s         = (state_q == ST_IDLE) && req_rd && !req_wr && !oor_now_s && buf_valid_q
                    && (idx_now_s == buf_idx_q);
    fast_oor_wr_s = (state_q == ST_IDLE) && req_wr && !req_rd && oor_now_s;
    accept_fast_s = buf_fill_s | fwd_s | fast_oor_wr_s;
    accept_slow_s = (state_q == ST_IDLE) && req_any_s && !accept_fast_s && !buf_valid_q;
    drain_now_s   = buf_valid_q && (drain_cnt_q == 4'd0) && !rst;
  end
`else
  // Any request seen in IDLE starts the wait-state sequence.
  always_comb begin
    accept_slow_s = (state_q == ST_IDLE) && req_any_s;
  end
`endif

  // Array port steering: completion writes/reads, zero load on illegal
  // accesses, plus buffer drain and forwarding when the buffer exists.
  always_comb begin
    arr_re_s    = done_go_s & rd_q & ~wr_q & ~oor_q;
    arr_raddr_s = idx_q;
`ifdef DMEM_WRITE_BUFFER_EN
    arr_we_s      = (done_go_s & wr_q & ~rd_q & ~oor_q) | drain_now_s;
    arr_waddr_s   = drain_now_s ? buf_idx_q : idx_q;
    arr_wdata_s   = drain_now_s ? buf_data_q : wdata_q;
    arr_ld_s      = (done_go_s & illegal_s) | fwd_s;
    arr_ld_data_s = fwd_s ? buf_data_q : {WORD_LEN{1'b0}};
`else
    arr_we_s      = done_go_s & wr_q & ~rd_q & ~oor_q;
    arr_waddr_s   = idx_q;
    arr_wdata_s   = wdata_q;
    arr_ld_s      = done_go_s & illegal_s;
    arr_ld_data_s = {WORD_LEN{1'b0}};
`endif
  end

  // Responder FSM with registered ready/err pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      oor_q   <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
`ifdef DMEM_WRITE_BUFFER_EN
          if (accept_fast_s) begin
            state_q <= ST_DONE;
            ready_q <= 1'b1;
            err_q   <= fast_oor_wr_s;
          end else
`endif
          if (accept_slow_s) begin
            state_q <= ST_WAIT;
            cnt_q   <= WAIT_LOAD;
            idx_q   <= idx_now_s;
            wdata_q <= req_wdata;
            rd_q    <= req_rd;
            wr_q    <= req_wr;
            oor_q   <= oor_now_s;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (!req_any_s) begin
            state_q <= ST_IDLE;
          end else if (cnt_q == 4'd0) begin
            state_q <= ST_DONE;
            ready_q <= 1'b1;
            err_q   <= illegal_s;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef DMEM_WRITE_BUFFER_EN
  // Posted-write buffer: fill on a fast write, drain into the array after
  // WAIT_CYCLES+1 cycles; reset discards the entry without writing it.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid_q <= 1'b0;
      buf_idx_q   <= '0;
      buf_data_q  <= '0;
      drain_cnt_q <= 4'd0;
    end else if (buf_fill_s) begin
      buf_valid_q <= 1'b1;
      buf_idx_q   <= idx_now_s;
      buf_data_q  <= req_wdata;
      drain_cnt_q <= WAIT_LOAD;
    end else if (buf_valid_q) begin
      if (drain_cnt_q == 4'd0) begin
        buf_valid_q <= 1'b0;
      end else begin
        drain_cnt_q <= drain_cnt_q - 4'd1;
      end
    end
  end
`endif

  dmem_array #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_LEN),
    .IDX_W (IDX_W)
  ) u_array (
    .clk_i     (clk),
    .rst_i     (rst),
    .we_i      (arr_we_s),
    .waddr_i   (arr_waddr_s),
    .wdata_i   (arr_wdata_s),
    .re_i      (arr_re_s),
    .raddr_i   (arr_raddr_s),
    .ld_i      (arr_ld_s),
    .ld_data_i (arr_ld_data_s),
    .rdata_o   (arr_rdata_s)
  );

  assign ready  = ready_q;
  assign err    = err_q;
  assign rdata  = arr_rdata_s;
  assign freeze = req_any_s & ~ready_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed, table-driven bench for data_mem_responder (WAIT_CYCLES=4,
// ADDR_BASE=1024, DEPTH=64), with hand-written abort and buffer sequences.
module tb_data_mem_responder;

  localparam int W = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_rd;
  logic        req_wr;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        ready;
  logic [31:0] rdata;
  logic        freeze;
  logic        err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  data_mem_responder #(
    .ADDR_BASE   (32'd1024),
    .DEPTH       (64),
    .WAIT_CYCLES (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_rd    (req_rd),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .ready     (ready),
    .rdata     (rdata),
    .freeze    (freeze),
    .err       (err)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        chk_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic rd, input logic wr);
`ifdef DMEM_WRITE_BUFFER_EN
    if (wr && !rd) return 1;
`endif
    return W + 2;
  endfunction

  // One held request: drive at a negedge, hold until ready (bounded), check.
  task automatic access(input string name, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int lat_exp, input logic [31:0] exp_rd,
                        input logic chk_rd, input logic exp_err);
    int   lat;
    logic fz_ok;
    @(negedge clk);
    req_rd = rd; req_wr = wr; req_addr = addr; req_wdata = wd;
    #1;
    fz_ok = (freeze === 1'b1) && (ready === 1'b0);
    lat = -1;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(negedge clk); #1;
      if (ready === 1'b1) lat = n;
      else if (freeze !== 1'b1) fz_ok = 1'b0;
    end
    chk({name, " latency"}, 32'(lat), 32'(lat_exp));
    chk({name, " freeze while pending"}, 32'(fz_ok), 32'd1);
    if (lat >= 0) begin
      chk({name, " freeze at ready"}, 32'(freeze), 32'd0);
      chk({name, " err"}, 32'(err), 32'(exp_err));
      if (chk_rd) chk({name, " rdata"}, rdata, exp_rd);
    end
    req_rd = 1'b0; req_wr = 1'b0;
  endtask

  task automatic watch_no_ready(input string name, input int cycles);
    int seen;
    seen = 0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk); #1;
      if (ready === 1'b1) seen++;
    end
    chk({name, " ready pulses"}, 32'(seen), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 32'd1024,   32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'd1024,   32'h0,        32'hDEADBEEF, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 32'd1028,   32'h12345678, 32'h0,        1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'h405,    32'h0,        32'h12345678, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 32'd1020,   32'h0,        32'h0,        1'b1, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 32'd1024,   32'h0,        32'hDEADBEEF, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 32'd1280,   32'h0,        32'h0,        1'b1, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 32'd1280,   32'hFFFFFFFF, 32'h0,        1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 32'd1024,   32'h0,        32'hDEADBEEF, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 32'd1028,   32'h0,        32'h12345678, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 32'd1032,   32'h0BADF00D, 32'h0,        1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 32'd1032,   32'h11111111, 32'h0,        1'b1, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 32'd1032,   32'h0,        32'h0BADF00D, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 32'd1276,   32'hCAFEF00D, 32'h0,        1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 32'd1276,   32'h0,        32'hCAFEF00D, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 32'd1020,   32'h22222222, 32'h0,        1'b0, 1'b1};
    vecs[16] = '{1'b1, 1'b0, 32'd1024,   32'h0,        32'hDEADBEEF, 1'b1, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 32'd1276,   32'h0,        32'hCAFEF00D, 1'b1, 1'b0};

    rst = 1'b1; req_rd = 1'b0; req_wr = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset ready", 32'(ready), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset rdata", rdata, 32'h0);
    chk("reset freeze", 32'(freeze), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      access($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd,
             exp_lat(vecs[i].rd, vecs[i].wr), vecs[i].exp_rd, vecs[i].chk_rd, vecs[i].exp_err);
      repeat (8) @(negedge clk);
    end

`ifndef DMEM_WRITE_BUFFER_EN
    // Request dropped two cycles in: aborted, no write.
    @(negedge clk);
    req_wr = 1'b1; req_addr = 32'd1024; req_wdata = 32'h77777777;
    repeat (2) @(negedge clk);
    req_wr = 1'b0;
    watch_no_ready("drop abort", 12);
    access("after drop", 1'b1, 1'b0, 32'd1024, 32'h0, W + 2, 32'hDEADBEEF, 1'b1, 1'b0);

    // Reset three cycles in: aborted, outputs cleared, no write.
    @(negedge clk);
    req_wr = 1'b1; req_addr = 32'd1024; req_wdata = 32'h66666666;
    repeat (3) @(negedge clk);
    rst = 1'b1; req_wr = 1'b0;
    @(negedge clk); #1;
    chk("mid reset rdata", rdata, 32'h0);
    chk("mid reset ready", 32'(ready), 32'd0);
    rst = 1'b0;
    watch_no_ready("reset abort", 12);
    access("after reset", 1'b1, 1'b0, 32'd1024, 32'h0, W + 2, 32'hDEADBEEF, 1'b1, 1'b0);
`else
    // Posted write, forwarded read, then a non-matching read that waits
    // for the drain (IDLE stall of two cycles) before a normal access.
    access("pre 1044", 1'b0, 1'b1, 32'd1044, 32'h5A5A0044, 1, 32'h0, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    access("post 1040", 1'b0, 1'b1, 32'd1040, 32'hA5A5A5A5, 1, 32'h0, 1'b0, 1'b0);
    access("fwd 1040", 1'b1, 1'b0, 32'd1040, 32'h0, 1, 32'hA5A5A5A5, 1'b1, 1'b0);
    access("drain wait 1044", 1'b1, 1'b0, 32'd1044, 32'h0, W + 4, 32'h5A5A0044, 1'b1, 1'b0);
    repeat (8) @(negedge clk);
    access("drained 1040", 1'b1, 1'b0, 32'd1040, 32'h0, W + 2, 32'hA5A5A5A5, 1'b1, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
